// File: rtl/nios_system_magnetic_sense.sv
// Avalon-MM input PIO for the magnetic sensors: per-bit 2-flop sync, debounce,
// edge capture with W1C clear, and a maskable level IRQ.
module nios_system_magnetic_sense #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edgecap;

    logic [WIDTH-1:0] w_fire;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd;
    logic             w_wr;

    // A bit fires when it has differed from stable for DEBOUNCE_CYCLES cycles.
    always_comb begin
        w_fire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_fire[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    always_comb begin
        w_set = '0;
        case (EDGE_TYPE)
            0:       w_set = w_fire & r_sync2;
            1:       w_set = w_fire & ~r_sync2;
            default: w_set = w_fire;
        endcase
    end

    assign w_wr  = chipselect && !write_n;
    assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_mask    <= '0;
            r_edgecap <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= in_port;
            r_sync2  <= r_sync1;
            // A firing bit always differs from stable, so toggling accepts sync2.
            r_stable <= r_stable ^ w_fire;
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i] || w_fire[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
            if (w_wr && address == 2'd2) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            // Set has priority over a same-cycle clear.
            r_edgecap <= (r_edgecap & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_rd = '0;
        case (address)
            2'd0:    w_rd = r_stable;
            2'd1:    w_rd = r_sync2;
            2'd2:    w_rd = r_mask;
            default: w_rd = r_edgecap;
        endcase
    end

    assign readdata = 32'(w_rd);
    assign irq      = |(r_edgecap & r_mask);

endmodule

// File: tb/tb_nios_system_magnetic_sense.sv
// Directed bench for nios_system_magnetic_sense: rising, falling and any-edge
// builds plus a single-cycle debounce build, all sharing one bus.
module tb_nios_system_magnetic_sense;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rdata0, rdata1, rdata2, rdata3;
    logic        irq_0, irq_1, irq_2, irq_3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nios_system_magnetic_sense #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata0), .irq(irq_0));
    nios_system_magnetic_sense #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata1), .irq(irq_1));
    nios_system_magnetic_sense #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata2), .irq(irq_2));
    nios_system_magnetic_sense #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) dut3 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata3), .irq(irq_3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; in_port = 8'h00; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        repeat (3) tick();
        reset = 1'b0;

        // 1: reset mid-debounce, then recovery with in_port held high
        wr(2'd2, 32'hFF);
        in_port = 8'hFF;
        repeat (8) tick();
        rd(2'd0); check("t1_pre_data", rdata0, 32'hFF);
        check("t1_pre_irq", {31'b0, irq_0}, 32'd1);
        in_port = 8'h00;
        repeat (3) tick();
        in_port = 8'hFF;
        reset = 1'b1;
        #1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            check("t1_rst_rd", rdata0, 32'h0);
        end
        check("t1_rst_irq", {31'b0, irq_0}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        repeat (5) tick();
        rd(2'd0); check("t1_data_e4", rdata0, 32'h00);
        tick();
        rd(2'd0); check("t1_data_e5", rdata0, 32'hFF);
        rd(2'd3); check("t1_ecap_rise", rdata0, 32'hFF);
        check("t1_ecap_fall", rdata1, 32'h00);
        check("t1_ecap_any", rdata2, 32'hFF);
        check("t1_irq_mask0", {31'b0, irq_0}, 32'd0);
        wr(2'd3, 32'hFF);

        // 2: latency of a single rising bit
        in_port = 8'h00;
        repeat (8) tick();
        wr(2'd3, 32'hFF);
        rd(2'd3); check("t2_ecap_clr", rdata1, 32'h00);
        in_port = 8'h01;
        tick();
        rd(2'd1); check("t2_raw_e0", rdata0, 32'h00);
        tick();
        rd(2'd1); check("t2_raw_e1", rdata0, 32'h01);
        rd(2'd0); check("t2_db1_e1", rdata3, 32'h00);
        tick();
        rd(2'd0); check("t2_db1_e2", rdata3, 32'h01);
        tick(); tick();
        rd(2'd0); check("t2_data_e4", rdata0, 32'h00);
        rd(2'd3); check("t2_ecap_e4", rdata0, 32'h00);
        tick();
        rd(2'd0); check("t2_data_e5", rdata0, 32'h01);
        rd(2'd3); check("t2_ecap_e5", rdata0, 32'h01);
        wr(2'd0, 32'h0);
        rd(2'd0); check("t2_data_ro", rdata0, 32'h01);
        wr(2'd1, 32'h0);
        rd(2'd1); check("t2_raw_ro", rdata0, 32'h01);

        // 3: 3-cycle glitch rejected, 4-cycle pulse accepted
        in_port = 8'h09;
        repeat (3) tick();
        in_port = 8'h01;
        repeat (8) tick();
        rd(2'd0); check("t3_glitch_data", rdata0, 32'h01);
        rd(2'd3); check("t3_glitch_ecap", rdata0, 32'h01);
        in_port = 8'h09;
        repeat (4) tick();
        in_port = 8'h01;
        repeat (2) tick();
        rd(2'd0); check("t3_pulse_data", rdata0, 32'h09);
        repeat (8) tick();
        rd(2'd3); check("t3_pulse_ecap", rdata0, 32'h09);
        rd(2'd0); check("t3_pulse_back", rdata0, 32'h01);

        // 4: mask, W1C and irq
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h01);
        in_port = 8'h00;
        repeat (8) tick();
        wr(2'd3, 32'hFF);
        in_port = 8'h05;
        repeat (8) tick();
        rd(2'd3); check("t4_ecap", rdata0, 32'h05);
        check("t4_ecap_fall", rdata1, 32'h00);
        check("t4_ecap_any", rdata2, 32'h05);
        check("t4_irq", {31'b0, irq_0}, 32'd1);
        check("t4_irq_fall", {31'b0, irq_1}, 32'd0);
        wr(2'd3, 32'h01);
        rd(2'd3); check("t4_w1c", rdata0, 32'h04);
        check("t4_irq_clr", {31'b0, irq_0}, 32'd0);
        wr(2'd2, 32'h04);
        check("t4_irq_mask4", {31'b0, irq_0}, 32'd1);
        wr(2'd2, 32'h00);
        check("t4_irq_mask0", {31'b0, irq_0}, 32'd0);
        rd(2'd3); check("t4_ecap_kept", rdata0, 32'h04);

        // 5: W1C on the same edge a new rising edge is accepted
        in_port = 8'h04;
        repeat (8) tick();
        wr(2'd3, 32'hFF);
        in_port = 8'h05;
        repeat (5) tick();
        wr(2'd3, 32'h01);
        rd(2'd3); check("t5_collide", rdata0, 32'h01);
        check("t5_collide_fall", rdata1, 32'h00);
        check("t5_collide_any", rdata2, 32'h01);
        wr(2'd3, 32'h01);
        rd(2'd3); check("t5_clear_after", rdata0, 32'h00);

        // 6: edge type builds on bit 7
        wr(2'd3, 32'hFF);
        in_port = 8'h85;
        repeat (8) tick();
        rd(2'd3); check("t6_rise_r", rdata0, 32'h80);
        check("t6_rise_f", rdata1, 32'h00);
        check("t6_rise_a", rdata2, 32'h80);
        wr(2'd3, 32'h00);
        rd(2'd3); check("t6_w0_noeffect", rdata2, 32'h80);
        wr(2'd3, 32'h80);
        rd(2'd3); check("t6_clr_a1", rdata2, 32'h00);
        in_port = 8'h05;
        repeat (8) tick();
        rd(2'd3); check("t6_fall_r", rdata0, 32'h00);
        check("t6_fall_f", rdata1, 32'h80);
        check("t6_fall_a", rdata2, 32'h80);
        wr(2'd3, 32'h80);
        rd(2'd3); check("t6_clr_f", rdata1, 32'h00);
        check("t6_clr_a2", rdata2, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
